// File: rtl/approx_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | approx_pkg : shared types and helpers for approximate-adder checks |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
package approx_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Unsigned add clamped to the all-ones value of a w-bit field (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (s > lim) ? lim[63:0] : s[63:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/approx_ed_calc.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | approx_ed_calc : exact sum and error distance |ref - apx|          |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
module approx_ed_calc
  import approx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  input  logic             op_cin,
  input  logic [WIDTH:0]   ref_val,
  input  logic [WIDTH:0]   apx_val,
  output logic [WIDTH:0]   exact,
  output logic [WIDTH:0]   ed
);

  assign exact = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, op_cin};
  assign ed    = (ref_val >= apx_val) ? (ref_val - apx_val) : (apx_val - ref_val);

endmodule
`default_nettype wire

// File: rtl/approx_err_monitor.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | approx_err_monitor : error statistics over a run of adder samples  |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16,
  parameter int ACC_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  input  logic             op_cin,
  input  logic [WIDTH-1:0] apx_sum,
  input  logic             apx_cout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH:0]   max_ed,
  output logic [ACC_W-1:0] sum_ed
);

  state_t           state;
  logic [CNT_W-1:0] remaining;

  logic             s1_valid;
  logic [WIDTH:0]   s1_exact;
  logic [WIDTH:0]   s1_apx;
  logic             s2_valid;
  logic [WIDTH:0]   s2_ed;

  logic [WIDTH:0]   exact_w;
  logic [WIDTH:0]   ed_w;
  logic             accept;
  logic             clear_stats;

  assign accept      = in_valid && in_ready;
  assign clear_stats = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Exact sum is taken from the live operands; ED from the stage-1 registers.
  approx_ed_calc #(.WIDTH(WIDTH)) u_ed_calc (
    .op_x    (op_x),
    .op_y    (op_y),
    .op_cin  (op_cin),
    .ref_val (s1_exact),
    .apx_val (s1_apx),
    .exact   (exact_w),
    .ed      (ed_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (num_samples != '0) begin
              state     <= ST_RUN;
              remaining <= num_samples;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              done      <= 1'b0;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state    <= ST_DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (!s1_valid && !s2_valid) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_exact <= '0;
      s1_apx   <= '0;
      s2_valid <= 1'b0;
      s2_ed    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_exact <= exact_w;
        s1_apx   <= {apx_cout, apx_sum};
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ed <= ed_w;
      end
    end
  end

  // A start is only honoured with the pipeline empty, so clear never races an update.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      err_count <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
    end else if (s2_valid) begin
      if (s2_ed != '0) begin
        err_count <= CNT_W'(sat_add(64'(err_count), 64'd1, CNT_W));
      end
      if (s2_ed > max_ed) begin
        max_ed <= s2_ed;
      end
      sum_ed <= ACC_W'(sat_add(64'(sum_ed), 64'(s2_ed), ACC_W));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_approx_err_monitor.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_approx_err_monitor : directed + random bench with ref model     |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
module tb_approx_err_monitor;

  localparam int WIDTH     = 8;
  localparam int CNT_W     = 16;
  localparam int ACC_W     = 25;
  localparam int ACC_W_SAT = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic             op_cin;
  logic [WIDTH-1:0] apx_sum;
  logic             apx_cout;

  logic                 in_ready, busy, done;
  logic [CNT_W-1:0]     err_count;
  logic [WIDTH:0]       max_ed;
  logic [ACC_W-1:0]     sum_ed;

  logic                 in_ready_s, busy_s, done_s;
  logic [CNT_W-1:0]     err_count_s;
  logic [WIDTH:0]       max_ed_s;
  logic [ACC_W_SAT-1:0] sum_ed_s;

  int     errors = 0;
  int     checks = 0;
  longint m_err, m_max, m_sum;

  always #5 clk = ~clk;

  approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .op_x(op_x), .op_y(op_y),
    .op_cin(op_cin), .apx_sum(apx_sum), .apx_cout(apx_cout),
    .busy(busy), .done(done), .err_count(err_count), .max_ed(max_ed),
    .sum_ed(sum_ed)
  );

  // Narrow-accumulator build, used to exercise saturation.
  approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W_SAT)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .op_x(op_x), .op_y(op_y),
    .op_cin(op_cin), .apx_sum(apx_sum), .apx_cout(apx_cout),
    .busy(busy_s), .done(done_s), .err_count(err_count_s), .max_ed(max_ed_s),
    .sum_ed(sum_ed_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    longint sat_sum;
    sat_sum = (m_sum > 1023) ? 1023 : m_sum;
    chk({tag, "_err"},     64'(err_count),   m_err);
    chk({tag, "_max"},     64'(max_ed),      m_max);
    chk({tag, "_sum"},     64'(sum_ed),      m_sum);
    chk({tag, "_sat_sum"}, 64'(sum_ed_s),    sat_sum);
    chk({tag, "_sat_max"}, 64'(max_ed_s),    m_max);
  endtask

  task automatic begin_run(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    m_err = 0; m_max = 0; m_sum = 0;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input int x, input int y, input int cin, input int apx);
    int t;
    int ex;
    int ed;
    op_x     = WIDTH'(x);
    op_y     = WIDTH'(y);
    op_cin   = 1'(cin);
    {apx_cout, apx_sum} = 9'(apx);
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    ex = x + y + cin;
    ed = (ex > apx) ? ex - apx : apx - ex;
    if (ed != 0) m_err++;
    if (ed > m_max) m_max = ed;
    m_sum += ed;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    check_stats(tag);
  endtask

  task automatic random_sample();
    int x, y, cin, ex, apx, mode;
    x    = $urandom_range(0, 255);
    y    = $urandom_range(0, 255);
    cin  = $urandom_range(0, 1);
    ex   = x + y + cin;
    mode = $urandom_range(0, 2);
    if (mode == 0)      apx = ex;
    else if (mode == 1) apx = $urandom_range(0, 511);
    else begin
      apx = ex + $urandom_range(0, 16) - 8;
      if (apx < 0)   apx = 0;
      if (apx > 511) apx = 511;
    end
    send(x, y, cin, apx);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    op_x = '0; op_y = '0; op_cin = 1'b0; apx_sum = '0; apx_cout = 1'b0;
    m_err = 0; m_max = 0; m_sum = 0;
    idle(3);
    chk("rst_ready", 64'(in_ready),  64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    check_stats("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single sample with latency checks.
    begin_run(1);
    chk("t1_busy",  64'(busy),     64'd1);
    chk("t1_ready", 64'(in_ready), 64'd1);
    chk("t1_done0", 64'(done),     64'd0);
    send(1, 0, 1, 3);
    chk("t1_ready_drop", 64'(in_ready),  64'd0);
    chk("t1_err_k0",     64'(err_count), 64'd0);
    @(negedge clk);
    chk("t1_done_k1", 64'(done),      64'd0);
    chk("t1_err_k1",  64'(err_count), 64'd0);
    @(negedge clk);
    chk("t1_done_k2", 64'(done),      64'd0);
    chk("t1_err_k2",  64'(err_count), 64'd1);
    @(negedge clk);
    chk("t1_done_k3", 64'(done), 64'd1);
    chk("t1_busy_k3", 64'(busy), 64'd0);
    check_stats("t1");
    chk("t1_sum_const", 64'(sum_ed), 64'd1);

    // Exact samples only.
    begin_run(4);
    send(8'hFF, 8'h01, 0, 9'h100);
    send(8'h00, 8'h00, 0, 9'h000);
    send(8'hFF, 8'hFF, 1, 9'h1FF);
    send(8'h12, 8'h34, 1, 9'h047);
    wait_done("t2");
    chk("t2_err_const", 64'(err_count), 64'd0);

    // Mixed run with bubbles: EDs 5, 0, 12.
    begin_run(3);
    idle(2);
    send(10, 0, 0, 15);
    idle(3);
    chk("t3_ready_bubble", 64'(in_ready), 64'd1);
    send(8'h20, 8'h20, 0, 9'h040);
    idle(2);
    chk("t3_ready_bubble2", 64'(in_ready), 64'd1);
    chk("t3_busy_bubble",   64'(busy),     64'd1);
    send(8'h80, 8'h80, 0, 9'h0F4);
    wait_done("t3");
    chk("t3_err_const", 64'(err_count), 64'd2);
    chk("t3_max_const", 64'(max_ed),    64'd12);
    chk("t3_sum_const", 64'(sum_ed),    64'd17);

    // Zero-length run from DONE clears stats.
    begin_run(0);
    chk("t4_done",  64'(done),     64'd1);
    chk("t4_ready", 64'(in_ready), 64'd0);
    chk("t4_busy",  64'(busy),     64'd0);
    check_stats("t4");

    // Zero-length run from IDLE after reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4b_done_rst", 64'(done), 64'd0);
    begin_run(0);
    chk("t4b_done",  64'(done),     64'd1);
    idle(3);
    chk("t4b_ready", 64'(in_ready), 64'd0);
    check_stats("t4b");

    // Start while busy is ignored.
    begin_run(2);
    send(3, 4, 0, 0);
    start = 1'b1; num_samples = CNT_W'(5);
    @(negedge clk);
    start = 1'b0;
    send(8'h40, 8'h01, 1, 9'h030);
    wait_done("t5");

    // Reset in the middle of a run.
    begin_run(4);
    send(100, 50, 0, 0);
    send(7, 7, 1, 200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_err = 0; m_max = 0; m_sum = 0;
    chk("t6_ready", 64'(in_ready), 64'd0);
    chk("t6_busy",  64'(busy),     64'd0);
    chk("t6_done",  64'(done),     64'd0);
    check_stats("t6");
    idle(3);
    check_stats("t6_late");
    begin_run(3);
    random_sample();
    random_sample();
    random_sample();
    wait_done("t6_rerun");

    // Randomised runs with random bubbles.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(3, 12);
      begin_run(n);
      for (int s = 0; s < n; s++) begin
        idle($urandom_range(0, 2));
        random_sample();
      end
      wait_done($sformatf("rnd%0d", r));
    end

    // Saturation in the narrow build: 8 x ED 255.
    begin_run(8);
    for (int s = 0; s < 8; s++) send(8'hFF, 8'hFF, 1, 9'h100);
    wait_done("t7");
    chk("t7_sat_sum_const", 64'(sum_ed_s), 64'd1023);
    chk("t7_sat_max_const", 64'(max_ed_s), 64'd255);
    chk("t7_sum_const",     64'(sum_ed),   64'd2040);
    chk("t7_sat_done",      64'(done_s),   64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
